// File: rtl/wb_mul_collector_pkg.sv
// Shared types and sizing for the multiplier writeback collector and its neighbours.
package wb_mul_collector_pkg;

   localparam int MUL_UNIT_NUM     = 2;
   localparam int PHY_REG_ID_WIDTH = 6;
   localparam int ROB_ID_WIDTH     = 6;

   typedef enum logic [4:0] {
      instruction_address_misaligned = 5'd0,
      instruction_access_fault       = 5'd1,
      illegal_instruction            = 5'd2,
      breakpoint                     = 5'd3,
      load_address_misaligned        = 5'd4,
      load_access_fault              = 5'd5,
      store_address_misaligned       = 5'd6,
      store_access_fault             = 5'd7,
      env_call_from_u_mode           = 5'd8,
      env_call_from_s_mode           = 5'd9,
      env_call_from_m_mode           = 5'd11
   } riscv_exception_t;

   typedef struct packed {
      logic                        enable;
      logic                        valid;
      logic [ROB_ID_WIDTH-1:0]     rob_id;
      logic                        rd_enable;
      logic                        need_rename;
      logic [PHY_REG_ID_WIDTH-1:0] rd_phy;
      logic [31:0]                 rd_value;
      logic                        has_exception;
      riscv_exception_t            exception_id;
      logic [31:0]                 exception_value;
   } execute_wb_pack_t;

   typedef struct packed {
      logic                        enable;
      logic [PHY_REG_ID_WIDTH-1:0] phy_id;
      logic [31:0]                 value;
   } execute_feedback_channel_t;

   typedef struct packed {
      logic enable;
      logic flush;
   } commit_feedback_pack_t;

   // A pack writes the register file only when it renames a real destination without faulting.
   function automatic logic wb_write_en(input execute_wb_pack_t p);
      return p.valid & p.rd_enable & p.need_rename & ~p.has_exception;
   endfunction

endpackage

// File: rtl/wb_mul_collector_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer, wrapping.
module rr_arbiter
   import wb_mul_collector_pkg::*;
#(
   parameter int N    = 2,
   parameter int ID_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic            advance,
   output logic [N-1:0]    grant,
   output logic [ID_W-1:0] grant_id
);

   logic [ID_W-1:0] rr_ptr_r;
   logic [ID_W-1:0] ptr_next_s;
   logic            found_s;
   int              best_d_s;
   int              best_j_s;

   // Pick the requester with the smallest wrapped distance from the pointer.
   always_comb begin
      int d;
      best_d_s = N;
      best_j_s = 0;
      for (int j = 0; j < N; j++) begin
         d = (j >= int'(rr_ptr_r)) ? (j - int'(rr_ptr_r)) : (j + N - int'(rr_ptr_r));
         if (req[j] && (d < best_d_s)) begin
            best_d_s = d;
            best_j_s = j;
         end else begin
            best_d_s = best_d_s;
         end
      end
      found_s  = (best_d_s < N);
      grant_id = ID_W'(best_j_s);
      for (int j = 0; j < N; j++) begin
         grant[j] = found_s && (best_j_s == j);
      end
      if (grant_id == ID_W'(N - 1)) begin
         ptr_next_s = {ID_W{1'b0}};
      end else begin
         ptr_next_s = grant_id + ID_W'(1);
      end
   end

   // Pointer moves past the granted unit only when the grant is actually taken.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rr_ptr_r <= {ID_W{1'b0}};
      end else if (advance && found_s) begin
         rr_ptr_r <= ptr_next_s;
      end else begin
         rr_ptr_r <= rr_ptr_r;
      end
   end

endmodule

// File: rtl/wb_mul_collector.sv
// Drains the multiplier writeback FIFOs one pack per cycle into the register file,
// the ROB finish port and the mul feedback channel.
module wb_mul_collector
   import wb_mul_collector_pkg::*;
#(
   parameter int MUL_UNIT_NUM     = wb_mul_collector_pkg::MUL_UNIT_NUM,
   parameter int PHY_REG_ID_WIDTH = wb_mul_collector_pkg::PHY_REG_ID_WIDTH,
   parameter int ROB_ID_WIDTH     = wb_mul_collector_pkg::ROB_ID_WIDTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  execute_wb_pack_t            mul_wb_fifo_data_out [MUL_UNIT_NUM],
   input  logic [MUL_UNIT_NUM-1:0]     mul_wb_fifo_data_out_valid,
   output logic [MUL_UNIT_NUM-1:0]     mul_wb_fifo_pop,
   input  commit_feedback_pack_t       commit_feedback_pack,
   output logic                        phyf_we,
   output logic [PHY_REG_ID_WIDTH-1:0] phyf_waddr,
   output logic [31:0]                 phyf_wdata,
   output logic                        rob_finish_we,
   output logic [ROB_ID_WIDTH-1:0]     rob_finish_id,
   output logic                        rob_finish_has_exception,
   output riscv_exception_t            rob_finish_exception_id,
   output logic [31:0]                 rob_finish_exception_value,
   output execute_feedback_channel_t   mul_wb_feedback_pack
);

   localparam int ID_W = (MUL_UNIT_NUM > 1) ? $clog2(MUL_UNIT_NUM) : 1;

   logic                    flush_now_s;
   logic                    pop_en_s;
   logic                    advance_s;
   logic [MUL_UNIT_NUM-1:0] grant_s;
   logic [ID_W-1:0]         grant_id_s;
   execute_wb_pack_t        out_pack_r;
   logic                    out_valid_s;
   logic                    exc_s;
   logic                    wr_s;

   assign flush_now_s     = commit_feedback_pack.enable & commit_feedback_pack.flush;
   assign pop_en_s        = rst & ~flush_now_s;
   assign advance_s       = pop_en_s & (|grant_s);
   assign mul_wb_fifo_pop = pop_en_s ? grant_s : {MUL_UNIT_NUM{1'b0}};

   rr_arbiter #(.N(MUL_UNIT_NUM), .ID_W(ID_W)) u_rr_arbiter (
      .clk      (clk),
      .rst      (rst),
      .req      (mul_wb_fifo_data_out_valid),
      .advance  (advance_s),
      .grant    (grant_s),
      .grant_id (grant_id_s)
   );

   // A disabled pack is stored as-is; its enable bit doubles as the output valid.
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_pack_r <= '0;
      end else if (advance_s) begin
         out_pack_r <= mul_wb_fifo_data_out[grant_id_s];
      end else begin
         out_pack_r <= '0;
      end
   end

   // Fan the held pack out to the three consumers, zeroing fields that are not qualified.
   always_comb begin
      out_valid_s   = out_pack_r.enable;
      exc_s         = out_valid_s & out_pack_r.has_exception;
      wr_s          = out_valid_s & wb_write_en(out_pack_r);
      rob_finish_we = out_valid_s;
      rob_finish_has_exception = exc_s;
      if (out_valid_s) begin
         rob_finish_id = out_pack_r.rob_id;
      end else begin
         rob_finish_id = {ROB_ID_WIDTH{1'b0}};
      end
      if (exc_s) begin
         rob_finish_exception_id    = out_pack_r.exception_id;
         rob_finish_exception_value = out_pack_r.exception_value;
      end else begin
         rob_finish_exception_id    = instruction_address_misaligned;
         rob_finish_exception_value = 32'd0;
      end
      if (wr_s) begin
         phyf_we    = 1'b1;
         phyf_waddr = out_pack_r.rd_phy;
         phyf_wdata = out_pack_r.rd_value;
      end else begin
         phyf_we    = 1'b0;
         phyf_waddr = {PHY_REG_ID_WIDTH{1'b0}};
         phyf_wdata = 32'd0;
      end
      mul_wb_feedback_pack.enable = phyf_we;
      mul_wb_feedback_pack.phy_id = phyf_waddr;
      mul_wb_feedback_pack.value  = phyf_wdata;
   end

endmodule

// File: tb/tb_wb_mul_collector.sv
// Scoreboard bench: per-unit FIFO model feeds the collector; a negedge monitor checks pops and outputs.
module tb_wb_mul_collector;
   import wb_mul_collector_pkg::*;

   typedef struct packed {
      logic                        rob_we;
      logic [ROB_ID_WIDTH-1:0]     rob_id;
      logic                        has_exc;
      riscv_exception_t            exc_id;
      logic [31:0]                 exc_val;
      logic                        wr;
      logic [PHY_REG_ID_WIDTH-1:0] waddr;
      logic [31:0]                 wdata;
   } exp_out_t;

   logic                        clk = 1'b0;
   logic                        rst;
   execute_wb_pack_t            data_out [MUL_UNIT_NUM];
   logic [MUL_UNIT_NUM-1:0]     data_valid;
   logic [MUL_UNIT_NUM-1:0]     pop;
   commit_feedback_pack_t       cfb;
   logic                        phyf_we;
   logic [PHY_REG_ID_WIDTH-1:0] phyf_waddr;
   logic [31:0]                 phyf_wdata;
   logic                        rob_finish_we;
   logic [ROB_ID_WIDTH-1:0]     rob_finish_id;
   logic                        rob_finish_has_exception;
   riscv_exception_t            rob_finish_exception_id;
   logic [31:0]                 rob_finish_exception_value;
   execute_feedback_channel_t   fb;

   execute_wb_pack_t        unit_q [MUL_UNIT_NUM][$];
   int                      exp_pop_q [$];
   exp_out_t                exp_out_q [$];
   logic [MUL_UNIT_NUM-1:0] pop_seen = '0;
   int                      errors = 0;
   int                      checks = 0;

   always #5 clk = ~clk;

   wb_mul_collector dut (
      .clk                        (clk),
      .rst                        (rst),
      .mul_wb_fifo_data_out       (data_out),
      .mul_wb_fifo_data_out_valid (data_valid),
      .mul_wb_fifo_pop            (pop),
      .commit_feedback_pack       (cfb),
      .phyf_we                    (phyf_we),
      .phyf_waddr                 (phyf_waddr),
      .phyf_wdata                 (phyf_wdata),
      .rob_finish_we              (rob_finish_we),
      .rob_finish_id              (rob_finish_id),
      .rob_finish_has_exception   (rob_finish_has_exception),
      .rob_finish_exception_id    (rob_finish_exception_id),
      .rob_finish_exception_value (rob_finish_exception_value),
      .mul_wb_feedback_pack       (fb)
   );

   task automatic check(input string name, input bit ok, input string detail);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: %s", name, detail);
      end
   endtask

   // Monitor: every negedge, compare whatever the DUT presents against the scoreboard.
   always @(negedge clk) begin
      exp_out_t act;
      exp_out_t e;
      logic [MUL_UNIT_NUM-1:0] want;
      int u;
      pop_seen <= pop;
      if (!rst || (cfb.enable && cfb.flush)) begin
         check("pop_blocked", pop == '0, $sformatf("pop=%b required=0", pop));
      end else if (pop != '0) begin
         if (exp_pop_q.size() == 0) begin
            check("unexpected_pop", 1'b0, $sformatf("pop=%b with no pop expected", pop));
         end else begin
            u = exp_pop_q.pop_front();
            want = '0;
            want[u] = 1'b1;
            check("pop_order", pop == want, $sformatf("pop=%b required=%b", pop, want));
         end
      end
      act = '{rob_finish_we, rob_finish_id, rob_finish_has_exception, rob_finish_exception_id,
              rob_finish_exception_value, phyf_we, phyf_waddr, phyf_wdata};
      if (rob_finish_we || phyf_we || fb.enable) begin
         if (exp_out_q.size() == 0) begin
            check("unexpected_output", 1'b0, $sformatf("got %h with nothing expected", act));
         end else begin
            e = exp_out_q.pop_front();
            check("output", (act == e) && (fb == {e.wr, e.waddr, e.wdata}),
                  $sformatf("got %h fb=%h required %h fb=%h", act, fb, e, {e.wr, e.waddr, e.wdata}));
         end
      end else begin
         check("idle_zero", (phyf_waddr == '0) && (phyf_wdata == 32'd0) && (fb == '0) &&
               (rob_finish_has_exception || ((rob_finish_exception_id == instruction_address_misaligned) &&
                                             (rob_finish_exception_value == 32'd0))),
               $sformatf("got %h fb=%h required zero fields", act, fb));
      end
   end

   task automatic drive();
      for (int u = 0; u < MUL_UNIT_NUM; u++) begin
         data_valid[u] = (unit_q[u].size() > 0);
         data_out[u]   = (unit_q[u].size() > 0) ? unit_q[u][0] : '0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      for (int u = 0; u < MUL_UNIT_NUM; u++) begin
         if (pop_seen[u] && (unit_q[u].size() > 0)) begin
            void'(unit_q[u].pop_front());
         end
      end
      drive();
   endtask

   task automatic load(input int u, input logic en, input logic vld, input logic rd_en,
                       input logic nr, input logic [5:0] rob, input logic [5:0] rd,
                       input logic [31:0] val, input logic exc, input riscv_exception_t eid,
                       input logic [31:0] ev, input logic exp_wr);
      execute_wb_pack_t p;
      exp_out_t e;
      p = '{en, vld, rob, rd_en, nr, rd, val, exc, eid, ev};
      unit_q[u].push_back(p);
      exp_pop_q.push_back(u);
      if (en) begin
         e = '{1'b1, rob, exc, exc ? eid : instruction_address_misaligned, exc ? ev : 32'd0,
               exp_wr, exp_wr ? rd : 6'd0, exp_wr ? val : 32'd0};
         exp_out_q.push_back(e);
      end
      drive();
   endtask

   task automatic set_flush(input logic f);
      cfb.enable = f;
      cfb.flush  = f;
   endtask

   initial begin
      rst = 1'b0;
      set_flush(1'b0);
      drive();
      // Reset with unit0 already holding a pack: nothing may pop until release.
      load(0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd1, 6'd3, 32'h0000_0011, 1'b0, illegal_instruction, 32'd0, 1'b1);
      tick();
      tick();
      rst = 1'b1;
      repeat (3) tick();

      // Single write from unit1.
      load(1, 1'b1, 1'b1, 1'b1, 1'b1, 6'd5, 6'd12, 32'h1234_5678, 1'b0, illegal_instruction, 32'd0, 1'b1);
      repeat (3) tick();

      // Fairness: both units loaded, expect 0,1,0,1.
      load(0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd10, 6'd20, 32'hAAAA_0001, 1'b0, illegal_instruction, 32'd0, 1'b1);
      load(1, 1'b1, 1'b1, 1'b1, 1'b1, 6'd11, 6'd21, 32'hBBBB_0002, 1'b0, illegal_instruction, 32'd0, 1'b1);
      load(0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd12, 6'd22, 32'hCCCC_0003, 1'b0, illegal_instruction, 32'd0, 1'b1);
      load(1, 1'b1, 1'b1, 1'b1, 1'b1, 6'd13, 6'd23, 32'hDDDD_0004, 1'b0, illegal_instruction, 32'd0, 1'b1);
      repeat (6) tick();

      // Exception: ROB finishes with the cause, no register write.
      load(1, 1'b1, 1'b1, 1'b1, 1'b1, 6'd7, 6'd30, 32'h5555_5555, 1'b1, illegal_instruction, 32'h0000_DEAD, 1'b0);
      repeat (3) tick();

      // Flush with both units pending: no pops, pointer stays at unit0.
      load(0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd14, 6'd40, 32'h0000_0040, 1'b0, illegal_instruction, 32'd0, 1'b1);
      load(1, 1'b1, 1'b1, 1'b1, 1'b1, 6'd15, 6'd41, 32'h0000_0041, 1'b0, illegal_instruction, 32'd0, 1'b1);
      set_flush(1'b1);
      tick();
      set_flush(1'b0);
      repeat (4) tick();

      // Entry already held when the flush arrives still drives its outputs.
      load(0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd16, 6'd42, 32'h0000_0042, 1'b0, illegal_instruction, 32'd0, 1'b1);
      tick();
      load(1, 1'b1, 1'b1, 1'b1, 1'b1, 6'd17, 6'd43, 32'h0000_0043, 1'b0, illegal_instruction, 32'd0, 1'b1);
      set_flush(1'b1);
      tick();
      set_flush(1'b0);
      repeat (3) tick();

      // Bubbles: disabled pack consumed silently; invalid pack finishes ROB without writing.
      load(0, 1'b0, 1'b1, 1'b1, 1'b1, 6'd18, 6'd44, 32'h0000_0044, 1'b0, illegal_instruction, 32'd0, 1'b0);
      repeat (2) tick();
      load(1, 1'b1, 1'b0, 1'b1, 1'b1, 6'd9, 6'd45, 32'h0000_0045, 1'b0, illegal_instruction, 32'd0, 1'b0);
      repeat (3) tick();

      // Reset mid-operation: held pack shows once, then everything clears and the pointer restarts.
      load(0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd20, 6'd46, 32'h0000_0046, 1'b0, illegal_instruction, 32'd0, 1'b1);
      tick();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      load(0, 1'b1, 1'b1, 1'b1, 1'b1, 6'd21, 6'd47, 32'h0000_0047, 1'b0, illegal_instruction, 32'd0, 1'b1);
      load(1, 1'b1, 1'b1, 1'b1, 1'b1, 6'd22, 6'd48, 32'h0000_0048, 1'b0, illegal_instruction, 32'd0, 1'b1);
      repeat (5) tick();

      check("pops_drained", exp_pop_q.size() == 0, $sformatf("pending pops=%0d required=0", exp_pop_q.size()));
      check("outputs_drained", exp_out_q.size() == 0, $sformatf("pending outputs=%0d required=0", exp_out_q.size()));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
